reg_file_32x32: RTL and testbench

- 32-entry x 32-bit MIPS general-purpose register file for the single-cycle CPU.
- Sits directly downstream of the 5-to-32 write-address decoder. It consumes that decoder's one-hot select to gate per-register write enables.
- Provides two asynchronous read ports (rs, rt) for the ID/EX datapath and one debug read port for the board display.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/reg_file_32x32_dec.sv | 9 +
 rtl/reg_file_32x32.sv | 82 ++++++++
 tb/tb_reg_file_32x32.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and architecturally special register numbers.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [REG_AW-1:0] REG_GP   = 5'd28;
  localparam logic [REG_AW-1:0] REG_SP   = 5'd29;
  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/reg_file_32x32_dec.sv
// 5-to-32 one-hot decoder used to form the register file write selects.
module Decoder5_32
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0]       addr_i,
  output logic [(1<<REG_AW)-1:0]  sel_o
);
  assign sel_o = {{((1<<REG_AW)-1){1'b0}}, 1'b1} << addr_i;
endmodule

// File: rtl/reg_file_32x32.sv
// MIPS 32x32 general-purpose register file: two async read ports with optional
// write bypass, a never-bypassed debug port, and a saturating write counter.
module reg_file_32x32
  import cpu_pkg::*;
#(
  parameter logic [DATA_W-1:0] SP_INIT = 32'h0000_2FFC,
  parameter logic [DATA_W-1:0] GP_INIT = 32'h0000_1800,
  parameter bit                BYPASS  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [REG_AW-1:0] RA1,
  input  logic [REG_AW-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic              WE,
  input  logic [REG_AW-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic [REG_AW-1:0] DBG_A,
  output logic [DATA_W-1:0] DBG_D,
  output logic [15:0]       WCNT
);
  logic [31:0]       sel;
  logic [31:0]       en;
  logic [DATA_W-1:0] regs_q [1:31];
  logic [15:0]       wcnt_q, wcnt_d;
  logic              wr_live;
  logic [DATA_W-1:0] rd1_raw, rd2_raw, dbg_raw;

  Decoder5_32 u_dec (
    .addr_i (WA),
    .sel_o  (sel)
  );

  // WE gates the decoder output so an unknown WA while idle cannot reach any flop.
  assign en      = {32{WE}} & sel & 32'hFFFF_FFFE;
  assign wr_live = WE && (WA != REG_ZERO);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 1; i < 32; i++) begin
        if (i == int'(REG_GP))      regs_q[i] <= GP_INIT;
        else if (i == int'(REG_SP)) regs_q[i] <= SP_INIT;
        else                        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (en[i]) regs_q[i] <= WD;
      end
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (wr_live && (wcnt_q != 16'hFFFF)) wcnt_d = wcnt_q + 16'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) wcnt_q <= '0;
    else        wcnt_q <= wcnt_d;
  end

  // $zero has no storage; address 0 is forced to zero ahead of any bypass.
  always_comb begin
    rd1_raw = '0;
    rd2_raw = '0;
    dbg_raw = '0;
    if (RA1   != REG_ZERO) rd1_raw = regs_q[RA1];
    if (RA2   != REG_ZERO) rd2_raw = regs_q[RA2];
    if (DBG_A != REG_ZERO) dbg_raw = regs_q[DBG_A];
  end

  always_comb begin
    RD1 = rd1_raw;
    RD2 = rd2_raw;
    if (BYPASS && wr_live && (RA1 == WA)) RD1 = WD;
    if (BYPASS && wr_live && (RA2 == WA)) RD2 = WD;
  end

  assign DBG_D = dbg_raw;
  assign WCNT  = wcnt_q;
endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: bypassing and non-bypassing instances
// share inputs; expected values come from a behavioural register model.
module tb_reg_file_32x32;
  logic        CLK = 1'b0;
  logic        RST_N;
  logic [4:0]  RA1, RA2, WA, DBG_A;
  logic        WE;
  logic [31:0] WD;
  logic [31:0] rd1, rd2, dbg, nb_rd1, nb_rd2, nb_dbg;
  logic [15:0] wcnt, nb_wcnt;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] mdl [32];
  int unsigned mcnt;
  int          n_chk  = 0;
  int          n_pass = 0;

  always #5 CLK = ~CLK;

  reg_file_32x32 #(.BYPASS(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .RA1(RA1), .RA2(RA2), .RD1(rd1), .RD2(rd2),
    .WE(WE), .WA(WA), .WD(WD), .DBG_A(DBG_A), .DBG_D(dbg), .WCNT(wcnt)
  );

  reg_file_32x32 #(.BYPASS(1'b0)) dut_nb (
    .CLK(CLK), .RST_N(RST_N), .RA1(RA1), .RA2(RA2), .RD1(nb_rd1), .RD2(nb_rd2),
    .WE(WE), .WA(WA), .WD(WD), .DBG_A(DBG_A), .DBG_D(nb_dbg), .WCNT(nb_wcnt)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return rd1;
      1:       return rd2;
      2:       return dbg;
      3:       return {16'h0, wcnt};
      4:       return nb_rd1;
      5:       return nb_rd2;
      6:       return {16'h0, nb_wcnt};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl[28] = 32'h0000_1800;
    mdl[29] = 32'h0000_2FFC;
    mcnt    = 0;
  endtask

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) begin
      mdl[a] = d;
      if (mcnt != 32'hFFFF) mcnt++;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; the model commits on that edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE = 1'b1; WA = a; WD = d;
    @(posedge CLK);
    model_write(a, d);
    #1 WE = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; WE = 1'b0; WA = '0; WD = '0; RA1 = '0; RA2 = '0; DBG_A = '0;
    model_reset();
    #12 RST_N = 1'b1;
    @(posedge CLK); #1;
    wr(5'd4, 32'h1234_5678);

    // Reset pulse between edges, no clock edge inside it.
    @(posedge CLK); #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    model_reset();
    RA1 = 5'd29; RA2 = 5'd28; DBG_A = 5'd5;
    push("rst_sp", 0, 32'h0000_2FFC);
    push("rst_gp", 1, 32'h0000_1800);
    push("rst_dbg5", 2, 32'h0);
    push("rst_wcnt", 3, 32'h0);
    drain();
    RA1 = 5'd4; push("rst_r4", 0, 32'h0);
    RA2 = 5'd0; push("rst_r0", 1, 32'h0);
    drain();

    @(posedge CLK); #1;
    wr(5'd8, 32'hDEAD_BEEF);
    RA1 = 5'd8; RA2 = 5'd7; DBG_A = 5'd9;
    push("wr_r8", 0, 32'hDEAD_BEEF);
    push("wr_r7", 1, mrd(5'd7));
    push("wr_r9", 2, mrd(5'd9));
    push("wr_wcnt", 3, mcnt);
    drain();

    // $zero write: reads of 0 stay zero during and after the write cycle.
    WE = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; RA1 = 5'd0; RA2 = 5'd0;
    push("z_during_rd1", 0, 32'h0);
    push("z_during_nb", 4, 32'h0);
    drain();
    @(posedge CLK); model_write(5'd0, 32'hFFFF_FFFF); #1 WE = 1'b0;
    DBG_A = 5'd0;
    push("z_after_rd1", 0, 32'h0);
    push("z_after_dbg", 2, 32'h0);
    push("z_wcnt", 3, mcnt);
    drain();

    wr(5'd3, 32'h11);
    WE = 1'b1; WA = 5'd3; WD = 32'h22; RA1 = 5'd3; RA2 = 5'd3; DBG_A = 5'd3;
    push("byp_rd1", 0, 32'h22);
    push("byp_rd2", 1, 32'h22);
    push("byp_dbg", 2, 32'h11);
    push("nobyp_rd1", 4, 32'h11);
    push("nobyp_rd2", 5, 32'h11);
    drain();
    @(posedge CLK); model_write(5'd3, 32'h22); #1 WE = 1'b0;
    push("post_rd1", 0, mrd(5'd3));
    push("post_dbg", 2, mrd(5'd3));
    push("post_nb_rd2", 5, mrd(5'd3));
    drain();

    // Idle with an unknown write address must not disturb any register.
    WA = 'x; WD = 32'hBAD0_BAD0;
    repeat (2) @(posedge CLK);
    #1 WA = '0;

    // Reset asserted across the edge of a pending write.
    WE = 1'b1; WA = 5'd31; WD = 32'h400;
    #2 RST_N = 1'b0;
    @(posedge CLK);
    #2 RST_N = 1'b1; WE = 1'b0;
    model_reset();
    RA1 = 5'd31; RA2 = 5'd3;
    push("rstw_r31", 0, 32'h0);
    push("rstw_r3", 1, 32'h0);
    push("rstw_wcnt", 3, 32'h0);
    push("rstw_nb_wcnt", 6, 32'h0);
    drain();

    @(posedge CLK); #1;
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    for (int i = 0; i < 32; i++) begin
      RA1 = 5'(i); RA2 = 5'(31 - i); DBG_A = 5'(i);
      push($sformatf("sw_rd1_%0d", i), 0, mrd(5'(i)));
      push($sformatf("sw_rd2_%0d", 31 - i), 1, mrd(5'(31 - i)));
      push($sformatf("sw_dbg_%0d", i), 2, mrd(5'(i)));
      drain();
    end
    push("sw_wcnt", 3, mcnt);
    drain();

    WE = 1'b1; WA = 5'd1; WD = 32'h5A5A_5A5A;
    repeat (65535 - int'(mcnt)) begin
      @(posedge CLK); model_write(5'd1, 32'h5A5A_5A5A);
    end
    #1 WE = 1'b0;
    push("sat_reach", 3, mcnt);
    drain();
    WE = 1'b1;
    repeat (5) begin
      @(posedge CLK); model_write(5'd1, 32'h5A5A_5A5A);
    end
    #1 WE = 1'b0;
    push("sat_hold", 3, 32'h0000_FFFF);
    push("sat_hold_nb", 6, 32'h0000_FFFF);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
